keypad_scanner: RTL
===================

// Module: keypad_scanner
// PURPOSE
//  Upstream of the tic-tac-toe game-state block. Scans the 3x4 phone-style keypad and debounces it.
//  Emits one single-cycle move code per physical press on key_data/key_valid (cells 1..9, specials 10..12).
//  Scanning runs only while scan_en=1; the top level drives scan_en = game-play mode (not main screen, no result).
// PARAMETERS
//  SCAN_DIV       25000  clk cycles per column dwell (1 kHz column rate at 25 MHz)
//  DEBOUNCE_SCANS 4      consecutive identical full-frame samples required for press and for release (>=2)
// PORTS
//  clk        in   1   system clock, rising edge
//  rst_n      in   1   synchronous, active-low reset
//  scan_en    in   1   1 = scan keypad; 0 = idle, clear all state
//  key_row    in   4   keypad row sense, active-low (row0 = keys 1,2,3 ... row3 = *,0,#)
//  key_col    out  3   keypad column drive, one-hot active-low
//  board      in   18  occupancy: {O1,X1,O2,X2,...,O9,X9}, bit 17 = O on cell 1; used only with the filter macro
//  key_data   out  4   move code while key_valid=1, else 0
//  key_valid  out  1   single-cycle strobe per accepted press
//  key_reject out  1   single-cycle strobe for a filtered press (constant 0 without the macro)
// BEHAVIOUR
//  Reset / scan_en=0 (both take priority):
//   - key_col=3'b111, key_data=0, key_valid=0, key_reject=0.
//   - Prescaler, column index, frame snapshot and debounce counters cleared; FSM -> IDLE.
//   - Reset or scan_en=0 mid-press: nothing emitted; the next press needs a full debounce from IDLE.
//  Prescaler: counts 0..SCAN_DIV-1 and wraps; tick = (count==SCAN_DIV-1).
//  Columns: key_col = 110 -> 101 -> 011 -> 110 ...
//   - Column 0 driven first cycle after scan_en rises.
//   - On each tick: sample key_row for the current column, then advance the column.
//   - Three ticks = one frame = 12-bit snapshot.
//  Candidate per frame: code of the single pressed key if exactly one bit is set, else 0.
//   - Ghost/multi-press frames therefore count as "no key".
//   - Key mapping: 1..9 -> 1..9, 0 -> 10, * -> 11, # -> 12.
//  Debounce FSM, evaluated once per frame end (stab = count of consecutive equal candidates, saturating at DEBOUNCE_SCANS):
//   IDLE     candidate!=0             -> PRESS_DB (latch cand, stab=1)
//   PRESS_DB cand changes             -> IDLE (a nonzero new cand re-enters PRESS_DB next frame)
//            stab reaches DEBOUNCE_SCANS -> emit, -> HELD
//   HELD     candidate==0             -> REL_DB (stab=1); anything else stays HELD (no auto-repeat)
//   REL_DB   candidate!=0             -> HELD
//            DEBOUNCE_SCANS zero frames -> IDLE
//  Emit: the cycle after the deciding frame end, key_valid=1 and key_data=code for exactly one clk.
//   - Both return to 0 the next cycle, so key_data gives one rising edge per press.
//   - Latency from stable press: DEBOUNCE_SCANS frames + 1 clk.
//  Width: prescaler $clog2(SCAN_DIV) bits; stab $clog2(DEBOUNCE_SCANS+1) bits, saturating, never wraps.
// CONFIGURATION
//  KEYPAD_OCC_FILTER_EN defined:
//   - Cell code k (1..9) is occupied when board[19-2k] | board[18-2k].
//   - Press on an occupied cell: key_reject pulses instead of key_valid; key_data stays 0.
//   - Codes 10..12 are never filtered. board is sampled in the emit cycle.
//  Not defined: board ignored, key_reject tied 0, every debounced press emitted.
// STRUCTURE
//  keypad_pkg: key codes (KEY_NONE=0, KEY_ZERO=10, KEY_STAR=11, KEY_HASH=12), FSM state enum,
//   function cell_occupied(board, code).
//  Sub-module keypad_debounce: frame candidate in, FSM + stab counter, emit strobe out.
//   Scanner top keeps prescaler, column drive, snapshot and the filter.
// TESTING (SCAN_DIV=4, DEBOUNCE_SCANS=3 for sim)
//  1. Reset held low, then released with scan_en=1 -> key_col=110 next cycle; all outputs 0 during reset.
//  2. Key 5 (row1, col1) held 10 frames -> exactly one key_valid with key_data=5, 3 frames + 1 clk after first stable frame.
//  3. Key 5 bouncing every frame for 6 frames, then stable -> single emit after 3 stable frames; held 20 frames -> no repeat.
//  4. Keys 1 and 2 pressed together -> no emit; release 2, keep 1 -> key_data=1 once.
//  5. scan_en dropped in frame 2 of a press, restored with key still held -> key_col=111 while low, then a fresh 3-frame debounce, one emit.
//  6. With KEYPAD_OCC_FILTER_EN: board[9]=1, press 5 -> key_reject one clk, key_valid 0;
//     press # -> key_data=12; without the macro, press 5 -> key_data=5.

Source files
------------

// File: rtl/keypad_pkg.sv
// Shared key codes, debounce state encoding and occupancy helper for the keypad scanner.
package keypad_pkg;

  localparam logic [3:0] KEY_NONE = 4'd0;
  localparam logic [3:0] KEY_ZERO = 4'd10;
  localparam logic [3:0] KEY_STAR = 4'd11;
  localparam logic [3:0] KEY_HASH = 4'd12;

  localparam int NUM_ROWS = 4;
  localparam int NUM_COLS = 3;
  localparam int SNAP_W   = NUM_ROWS * NUM_COLS;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PRESS_DB,
    ST_HELD,
    ST_REL_DB
  } db_state_t;

  // Bottom row carries the phone-style specials: * 0 #
  function automatic logic [3:0] key_code(input logic [1:0] row, input logic [1:0] col);
    logic [3:0] code;
    if (row == 2'd3) begin
      case (col)
        2'd0:    code = KEY_STAR;
        2'd1:    code = KEY_ZERO;
        default: code = KEY_HASH;
      endcase
    end else begin
      code = ({2'b00, row} * 4'd3) + {2'b00, col} + 4'd1;
    end
    return code;
  endfunction

  // Cell k owns the pair {O,X} at bits 19-2k and 18-2k; specials never map to a cell.
  function automatic logic cell_occupied(input logic [17:0] board, input logic [3:0] code);
    logic [17:0] shifted;
    if (code == KEY_NONE || code > 4'd9) begin
      return 1'b0;
    end
    shifted = board >> (5'd18 - {code, 1'b0});
    return shifted[1] | shifted[0];
  endfunction

endpackage

// File: rtl/keypad_scanner_if.sv
// Keypad scanner signal bundle: master is the scanner, slave is the keypad/game side.
interface keypad_scanner_if;
  logic        scan_en;
  logic [3:0]  key_row;
  logic [2:0]  key_col;
  logic [17:0] board;
  logic [3:0]  key_data;
  logic        key_valid;
  logic        key_reject;

  modport master (
    input  scan_en, key_row, board,
    output key_col, key_data, key_valid, key_reject
  );

  modport slave (
    output scan_en, key_row, board,
    input  key_col, key_data, key_valid, key_reject
  );
endinterface

// File: rtl/keypad_debounce.sv
// Frame-rate debounce: turns one candidate code per scan frame into a single emit strobe per press.
module keypad_debounce
  import keypad_pkg::*;
#(
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clear,
  input  logic       frame_done,
  input  logic [3:0] cand,
  output logic       emit,
  output logic [3:0] emit_code
);

  localparam int STAB_W = $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [STAB_W-1:0] STAB_MAX = STAB_W'(DEBOUNCE_SCANS);

  db_state_t         state, state_n;
  logic [3:0]        code, code_n;
  logic [STAB_W-1:0] stab, stab_n, stab_inc;
  logic              emit_n;
  logic [3:0]        emit_code_n;

  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      state     <= ST_IDLE;
      code      <= KEY_NONE;
      stab      <= '0;
      emit      <= 1'b0;
      emit_code <= KEY_NONE;
    end else begin
      state     <= state_n;
      code      <= code_n;
      stab      <= stab_n;
      emit      <= emit_n;
      emit_code <= emit_code_n;
    end
  end

  assign stab_inc = (stab == STAB_MAX) ? stab : stab + 1'b1;

  // The FSM only moves on frame boundaries; between them everything holds.
  always_comb begin
    state_n     = state;
    code_n      = code;
    stab_n      = stab;
    emit_n      = 1'b0;
    emit_code_n = emit_code;
    if (frame_done) begin
      case (state)
        ST_IDLE: begin
          if (cand != KEY_NONE) begin
            state_n = ST_PRESS_DB;
            code_n  = cand;
            stab_n  = STAB_W'(1);
          end
        end
        ST_PRESS_DB: begin
          if (cand != code) begin
            state_n = ST_IDLE;
            code_n  = KEY_NONE;
            stab_n  = '0;
          end else begin
            stab_n = stab_inc;
            if (stab_inc == STAB_MAX) begin
              state_n     = ST_HELD;
              emit_n      = 1'b1;
              emit_code_n = code;
            end
          end
        end
        ST_HELD: begin
          if (cand == KEY_NONE) begin
            state_n = ST_REL_DB;
            stab_n  = STAB_W'(1);
          end
        end
        ST_REL_DB: begin
          if (cand != KEY_NONE) begin
            state_n = ST_HELD;
            stab_n  = '0;
          end else begin
            stab_n = stab_inc;
            if (stab_inc == STAB_MAX) begin
              state_n = ST_IDLE;
              code_n  = KEY_NONE;
              stab_n  = '0;
            end
          end
        end
        default: begin
          state_n = ST_IDLE;
          code_n  = KEY_NONE;
          stab_n  = '0;
        end
      endcase
    end
  end

endmodule

// File: rtl/keypad_scanner.sv
// 3x4 keypad column scanner with debounced single-cycle move codes.
// Optional occupancy filter enabled by defining KEYPAD_OCC_FILTER_EN.
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV       = 25000,
  parameter int DEBOUNCE_SCANS = 4
) (
  input logic              clk,
  input logic              rst_n,
  keypad_scanner_if.master kp
);

  localparam int CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_DIV - 1);

  logic [CNT_W-1:0]  pre_cnt;
  logic [1:0]        col_idx;
  logic              active;
  logic [SNAP_W-1:0] snapshot, snap_next;
  logic              tick, frame_done, clear;
  logic [3:0]        cand;
  logic              emit;
  logic [3:0]        emit_code;
  logic              accept, reject;

  assign clear      = !rst_n || !kp.scan_en;
  assign tick       = active && (pre_cnt == CNT_LAST);
  assign frame_done = tick && (col_idx == 2'd2);

  // 'active' delays the prescaler by one cycle so column 0 gets a full dwell after enable.
  always_ff @(posedge clk) begin
    if (clear) begin
      active   <= 1'b0;
      pre_cnt  <= '0;
      col_idx  <= 2'd0;
      snapshot <= '0;
    end else begin
      active <= 1'b1;
      if (active) begin
        if (tick) begin
          pre_cnt  <= '0;
          snapshot <= snap_next;
          col_idx  <= (col_idx == 2'd2) ? 2'd0 : col_idx + 2'd1;
        end else begin
          pre_cnt <= pre_cnt + 1'b1;
        end
      end
    end
  end

  always_comb begin
    snap_next = snapshot;
    snap_next[{col_idx, 2'b00} +: NUM_ROWS] = ~kp.key_row;
  end

  // Anything other than exactly one closed contact (nothing, chords, ghosts) reads as no key.
  always_comb begin
    cand = KEY_NONE;
    if ($countones(snap_next) == 1) begin
      for (int c = 0; c < NUM_COLS; c++) begin
        for (int r = 0; r < NUM_ROWS; r++) begin
          if (snap_next[c*NUM_ROWS + r]) begin
            cand = key_code(2'(r), 2'(c));
          end
        end
      end
    end
  end

  keypad_debounce #(
    .DEBOUNCE_SCANS(DEBOUNCE_SCANS)
  ) u_debounce (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (!kp.scan_en),
    .frame_done(frame_done),
    .cand      (cand),
    .emit      (emit),
    .emit_code (emit_code)
  );

`ifdef KEYPAD_OCC_FILTER_EN
  logic occupied;
  assign occupied = cell_occupied(kp.board, emit_code);
  assign accept   = emit && kp.scan_en && !occupied;
  assign reject   = emit && kp.scan_en && occupied;
`else
  logic unused_board;
  assign unused_board = ^kp.board;
  assign accept       = emit && kp.scan_en;
  assign reject       = 1'b0;
`endif

  assign kp.key_valid  = accept;
  assign kp.key_reject = reject;
  assign kp.key_data   = accept ? emit_code : KEY_NONE;
  assign kp.key_col    = (active && kp.scan_en) ? ~(3'b001 << col_idx) : 3'b111;

endmodule
